// File: rtl/ball_trajectory_tracker.sv
// ball_trajectory_tracker
//   Follows the per-frame ball hotbox from the detector. Each frame strobe
//   passes the detected cell through a plausibility gate and builds
//   confidence over consecutive frames. It also estimates the grid velocity.
//   When the ball heads toward the paddle row, a multi-cycle extrapolation
//   predicts the landing column, reflecting off the side walls. The predicted
//   column goes to the paddle/servo controller.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   FRAME_DONE          one-cycle frame strobe; BALL_* valid in that cycle
//   BALL_X, BALL_Y      detected hotbox column / row
//   BALL_VALID          detector found a ball this frame
//   TARGET_READY        consumer accepts TARGET_X
//   TARGET_X            predicted landing column
//   TARGET_VALID        TARGET_X holds an unconsumed prediction
//   OVERRUN             one-cycle pulse: unconsumed prediction overwritten
//   VEL_X, VEL_Y        signed velocity estimate, cells/frame
//   STATE               IDLE=0, ACQUIRE=1, TRACK=2, PREDICT=3
//   TRACKING            STATE is TRACK or PREDICT
module ball_trajectory_tracker #(
   parameter int COLS        = 40,
   parameter int ROWS        = 30,
   parameter int TARGET_ROW  = 29,
   parameter int ACQ_FRAMES  = 3,
   parameter int MAX_STEP    = 4,
   parameter int LOST_FRAMES = 5
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FRAME_DONE,
   input  logic [5:0]        BALL_X,
   input  logic [5:0]        BALL_Y,
   input  logic              BALL_VALID,
   input  logic              TARGET_READY,
   output logic [5:0]        TARGET_X,
   output logic              TARGET_VALID,
   output logic              OVERRUN,
   output logic signed [6:0] VEL_X,
   output logic signed [6:0] VEL_Y,
   output logic [1:0]        STATE,
   output logic              TRACKING
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      PREDICT = 2'd3
   } state_t;

   localparam logic signed [6:0] STEP_P   = 7'(MAX_STEP);
   localparam logic signed [6:0] STEP_N   = 7'(-MAX_STEP);
   localparam logic signed [7:0] X_MAX    = 8'(COLS - 1);
   localparam logic signed [7:0] X_MAX2   = 8'(2 * (COLS - 1));
   localparam logic signed [7:0] Y_TGT8   = 8'(TARGET_ROW);
   localparam logic [5:0]        Y_TGT    = 6'(TARGET_ROW);
   localparam logic [3:0]        ACQ_N    = 4'(ACQ_FRAMES);
   localparam logic [3:0]        LOST_N   = 4'(LOST_FRAMES);
   // A prediction never needs more than ROWS steps; the step counter
   // bounds the loop even if the row arithmetic were to misbehave.
   localparam logic [4:0]        STEP_LIM = 5'(ROWS - 1);

   state_t                state_q, state_n;
   logic [5:0]            prev_x_q, prev_x_n, prev_y_q, prev_y_n;
   logic [3:0]            acq_q, acq_n, miss_q, miss_n;
   logic signed [7:0]     px_q, px_n, py_q, py_n;
   logic signed [6:0]     vel_x_q, vel_x_n, vel_y_q, vel_y_n;
   logic signed [6:0]     pvx_q, pvx_n, pvy_q, pvy_n;
   logic [4:0]            step_q, step_n;
   logic                  pend_q, pend_n, pend_v_q, pend_v_n;
   logic [5:0]            pend_x_q, pend_x_n, pend_y_q, pend_y_n;
   logic [5:0]            tx_q, tx_n;
   logic                  tv_q, tv_n, ovr_q, ovr_n;

   // Frame under evaluation: a frame captured during PREDICT is replayed
   // ahead of any live strobe once the FSM leaves PREDICT.
   logic                  evt, fv, plaus, load;
   logic [5:0]            fx, fy;
   logic signed [6:0]     dx, dy, refl_vx;
   logic signed [7:0]     step_x, step_y, refl_x;

   assign evt    = FRAME_DONE | pend_q;
   assign fx     = pend_q ? pend_x_q : BALL_X;
   assign fy     = pend_q ? pend_y_q : BALL_Y;
   assign fv     = pend_q ? pend_v_q : BALL_VALID;
   assign dx     = {1'b0, fx} - {1'b0, prev_x_q};
   assign dy     = {1'b0, fy} - {1'b0, prev_y_q};
   assign plaus  = fv && (dx <= STEP_P) && (dx >= STEP_N) &&
                   (dy <= STEP_P) && (dy >= STEP_N);
   assign step_x = px_q + {pvx_q[6], pvx_q};
   assign step_y = py_q + {pvy_q[6], pvy_q};

   // Wall reflection folds an overshoot back inside 0..COLS-1.
   always_comb begin
      refl_x  = step_x;
      refl_vx = pvx_q;
      if (step_x < 8'sd0) begin
         refl_x  = -step_x;
         refl_vx = -pvx_q;
      end else if (step_x > X_MAX) begin
         refl_x  = X_MAX2 - step_x;
         refl_vx = -pvx_q;
      end
   end

   always_comb begin
      state_n  = state_q;
      prev_x_n = prev_x_q;
      prev_y_n = prev_y_q;
      acq_n    = acq_q;
      miss_n   = miss_q;
      vel_x_n  = vel_x_q;
      vel_y_n  = vel_y_q;
      px_n     = px_q;
      py_n     = py_q;
      pvx_n    = pvx_q;
      pvy_n    = pvy_q;
      step_n   = step_q;
      pend_n   = pend_q;
      pend_x_n = pend_x_q;
      pend_y_n = pend_y_q;
      pend_v_n = pend_v_q;
      load     = 1'b0;

      if (state_q == PREDICT) begin
         if (FRAME_DONE) begin
            pend_n   = 1'b1;
            pend_x_n = BALL_X;
            pend_y_n = BALL_Y;
            pend_v_n = BALL_VALID;
         end
         px_n   = refl_x;
         py_n   = step_y;
         pvx_n  = refl_vx;
         step_n = step_q + 5'd1;
         if (step_y >= Y_TGT8 || step_q == STEP_LIM) begin
            load    = 1'b1;
            state_n = TRACK;
         end
      end else if (evt) begin
         // Replaying a pending frame while a live strobe arrives: the live
         // frame becomes the next pending one instead of being dropped.
         pend_n = pend_q & FRAME_DONE;
         if (pend_q && FRAME_DONE) begin
            pend_x_n = BALL_X;
            pend_y_n = BALL_Y;
            pend_v_n = BALL_VALID;
         end
         case (state_q)
            IDLE: begin
               if (fv) begin
                  prev_x_n = fx;
                  prev_y_n = fy;
                  acq_n    = 4'd1;
                  state_n  = ACQUIRE;
               end
            end
            ACQUIRE: begin
               if (plaus) begin
                  prev_x_n = fx;
                  prev_y_n = fy;
                  vel_x_n  = dx;
                  vel_y_n  = dy;
                  acq_n    = acq_q + 4'd1;
                  if (acq_q + 4'd1 == ACQ_N) begin
                     miss_n  = 4'd0;
                     state_n = TRACK;
                  end
               end else if (fv) begin
                  prev_x_n = fx;
                  prev_y_n = fy;
                  acq_n    = 4'd1;
               end else begin
                  state_n = IDLE;
               end
            end
            TRACK: begin
               if (plaus) begin
                  prev_x_n = fx;
                  prev_y_n = fy;
                  vel_x_n  = dx;
                  vel_y_n  = dy;
                  miss_n   = 4'd0;
                  if (dy > 7'sd0 && fy < Y_TGT) begin
                     px_n    = {2'b00, fx};
                     py_n    = {2'b00, fy};
                     pvx_n   = dx;
                     pvy_n   = dy;
                     step_n  = 5'd0;
                     state_n = PREDICT;
                  end
               end else begin
                  miss_n = miss_q + 4'd1;
                  if (miss_q + 4'd1 == LOST_N) begin
                     miss_n  = 4'd0;
                     vel_x_n = 7'sd0;
                     vel_y_n = 7'sd0;
                     state_n = IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output handshake: a transfer happens on any cycle with TARGET_VALID and
   // TARGET_READY both high; VALID then drops on the next edge unless a new
   // result loads on that same edge, in which case the new TARGET_X is shown
   // and VALID stays high. A load onto an unaccepted result (VALID=1,
   // READY=0) replaces TARGET_X and raises OVERRUN for one cycle.
   always_comb begin
      tx_n  = tx_q;
      tv_n  = tv_q;
      ovr_n = 1'b0;
      if (tv_q && TARGET_READY) tv_n = 1'b0;
      if (load) begin
         tx_n  = refl_x[5:0];
         tv_n  = 1'b1;
         ovr_n = tv_q & ~TARGET_READY;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         prev_x_q <= '0;
         prev_y_q <= '0;
         acq_q    <= '0;
         miss_q   <= '0;
         vel_x_q  <= '0;
         vel_y_q  <= '0;
         px_q     <= '0;
         py_q     <= '0;
         pvx_q    <= '0;
         pvy_q    <= '0;
         step_q   <= '0;
         pend_q   <= 1'b0;
         pend_x_q <= '0;
         pend_y_q <= '0;
         pend_v_q <= 1'b0;
         tx_q     <= '0;
         tv_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         prev_x_q <= prev_x_n;
         prev_y_q <= prev_y_n;
         acq_q    <= acq_n;
         miss_q   <= miss_n;
         vel_x_q  <= vel_x_n;
         vel_y_q  <= vel_y_n;
         px_q     <= px_n;
         py_q     <= py_n;
         pvx_q    <= pvx_n;
         pvy_q    <= pvy_n;
         step_q   <= step_n;
         pend_q   <= pend_n;
         pend_x_q <= pend_x_n;
         pend_y_q <= pend_y_n;
         pend_v_q <= pend_v_n;
         tx_q     <= tx_n;
         tv_q     <= tv_n;
         ovr_q    <= ovr_n;
      end
   end

   assign TARGET_X     = tx_q;
   assign TARGET_VALID = tv_q;
   assign OVERRUN      = ovr_q;
   assign VEL_X        = vel_x_q;
   assign VEL_Y        = vel_y_q;
   assign STATE        = state_q;
   assign TRACKING     = (state_q == TRACK) || (state_q == PREDICT);

endmodule

// File: doc/ball_trajectory_tracker.md
# ball_trajectory_tracker

Downstream consumer of the per-frame ball hotbox coordinates (40x30 grid of 16x16 blocks) that the ball detection stage produces. On each frame strobe it applies a plausibility gate to the detected cell, builds confidence over consecutive frames, and estimates grid velocity. When the ball moves toward the paddle row, it runs a multi-cycle extrapolation, with reflection off the side walls, to predict the landing column. The prediction goes to the paddle/servo controller over a valid/ready handshake.

## Interface
- COLS, 40, grid columns; x range 0..COLS-1
- ROWS, 30, grid rows
- TARGET_ROW, 29, paddle row the ball is extrapolated to
- ACQ_FRAMES, 3, consecutive plausible detections required to enter tracking
- MAX_STEP, 4, max per-axis jump (cells/frame) accepted as plausible; must be < COLS-1
- LOST_FRAMES, 5, consecutive misses in tracking before dropping to IDLE

- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- FRAME_DONE  in  1  one-cycle pulse; BALL_X/BALL_Y/BALL_VALID stable this cycle
- BALL_X  in  6  detected hotbox column
- BALL_Y  in  6  detected hotbox row
- BALL_VALID  in  1  detector found a ball this frame
- TARGET_READY  in  1  consumer accepts TARGET_X
- TARGET_X  out  6  predicted landing column
- TARGET_VALID  out  1  TARGET_X holds an unconsumed prediction
- OVERRUN  out  1  one-cycle pulse: unconsumed prediction overwritten
- VEL_X, VEL_Y  out  7  signed two's-complement velocity, cells/frame
- STATE  out  2  IDLE=0, ACQUIRE=1, TRACK=2, PREDICT=3
- TRACKING  out  1  STATE is TRACK or PREDICT

## Operation
- Registers: prev (x,y), acq_cnt, miss_cnt, signed px/py (8b), vx/vy, pending flag.
- A sample p is plausible if BALL_VALID=1 and |p.x-prev.x| ≤ MAX_STEP and |p.y-prev.y| ≤ MAX_STEP.
- The FSM evaluates only on FRAME_DONE, except in PREDICT:
  - IDLE: if BALL_VALID, set prev=p, acq_cnt=1, go to ACQUIRE.
  - ACQUIRE:
    - Plausible: prev=p, acq_cnt++, VEL=p-prev. When acq_cnt reaches ACQ_FRAMES, go to TRACK and clear miss_cnt. No prediction is made on this transition.
    - Valid but implausible: restart with prev=p, acq_cnt=1.
    - Invalid: go to IDLE.
  - TRACK:
    - Plausible: VEL=p-prev, prev=p, miss_cnt=0. If the new VEL_Y>0 and p.y<TARGET_ROW, load px=p.x, py=p.y, vx/vy=VEL and go to PREDICT.
    - Otherwise: miss_cnt++; prev and VEL hold. When miss_cnt reaches LOST_FRAMES, go to IDLE and zero VEL.
  - PREDICT: one step per cycle: py+=vy, px+=vx.
    - If px<0: px=-px, vx=-vx.
    - If px>COLS-1: px=2(COLS-1)-px, vx=-vx.
    - When py ≥ TARGET_ROW: load TARGET_X=px[5:0], assert TARGET_VALID, return to TRACK.
- FRAME_DONE during PREDICT sets pending, capturing BALL_X/BALL_Y/BALL_VALID. Pending is processed as a TRACK frame in the first cycle after the PREDICT exit. A further FRAME_DONE overwrites the pending capture.
- Handshake:
  - A transfer occurs when TARGET_VALID & TARGET_READY.
  - TARGET_VALID falls the next cycle unless a new result loads that same cycle. In that case the new value is presented and VALID stays high.
  - A result loading while TARGET_VALID=1 and TARGET_READY=0 overwrites TARGET_X and pulses OVERRUN.

## Timing
- Reset (async assert, sync release): STATE=IDLE, TARGET_X=0, TARGET_VALID=0, OVERRUN=0, VEL_X=VEL_Y=0, TRACKING=0, all counters and pending cleared. Reset asserted in PREDICT aborts the prediction with no output.
- FRAME_DONE is sampled at edge t0. STATE/VEL update at t0 and are visible from t0+.
- Prediction needing k steps: k = ceil((TARGET_ROW-y)/vy), at most ROWS. Steps occur at edges t0+1..t0+k. TARGET_VALID rises at edge t0+k, in the same edge as STATE returns to TRACK.
- A pending frame is evaluated at edge t0+k+1.

## Test plan
- Reset in PREDICT: RST_N low for 1 cycle during a 9-step prediction -> all outputs 0, STATE=0 immediately; no TARGET_VALID afterwards.
- Acquisition and straight prediction:
  - Frames (10,5),(11,7),(12,9) valid -> STATE=2 after the 3rd, VEL=(1,2), TARGET_VALID=0.
  - Frame (13,11) -> STATE=3; TARGET_X=22 and TARGET_VALID=1 exactly 9 cycles after the FRAME_DONE edge.
- Wall reflection: frames (28,19),(31,21),(34,23) then (37,25) -> VEL=(3,2); step 1 px 40→38; step 2 TARGET_X=35 after 2 cycles.
- Gating and loss:
  - In TRACK at prev (20,10), frame (27,10) -> miss, VEL unchanged, STATE=2.
  - 5 consecutive BALL_VALID=0 frames -> STATE=0, VEL=(0,0).
- Handshake: TARGET_READY=0 across two predictions -> second overwrites TARGET_X, OVERRUN pulses 1 cycle. READY=1 for one cycle -> TARGET_VALID=0 the next cycle.
- Pending frame: FRAME_DONE at step 3 of a 9-step prediction with (15,13) -> processed at t0+10; the new prediction starts from (15,13).
